// File: rtl/processor_run_monitor.sv
// Run controller and cycle monitor for a small processor array: launches enabled
// cores on go, records per-core finish latency, and ends on completion or timeout.
//
// state | meaning
// IDLE  | after reset, waiting for go
// RUN   | start asserted to enabled cores, cycle counter running
// DONE  | run ended, results held until the next go
module processor_run_monitor #(
  parameter int NUM_CORES      = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [NUM_CORES-1:0]       core_en,
  input  logic [NUM_CORES-1:0]       finish_process,
  output logic [NUM_CORES-1:0]       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [NUM_CORES-1:0]       finish_mask,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_CORES*CNT_W-1:0] latency_flat
);

  if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_cores
    $error("processor_run_monitor: NUM_CORES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 0 || (CNT_W < 31 && TIMEOUT_CYCLES > (1 << CNT_W) - 1)) begin : g_bad_tmo
    $error("processor_run_monitor: TIMEOUT_CYCLES does not fit the cycle counter");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only meaningful when TIMEOUT_CYCLES != 0; the compare is gated below.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [NUM_CORES-1:0]   en_q;
  logic [NUM_CORES-1:0]   start_q;
  logic                   done_q;
  logic                   timeout_q;
  logic [NUM_CORES-1:0]   finish_mask_q;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [CNT_W-1:0]       cycle_count_d;
  logic [CNT_W-1:0]       latency_q [NUM_CORES];
  logic [NUM_CORES-1:0]   fin_new;
  logic                   all_fin;
  logic                   tmo_hit;

  always_comb begin
    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    fin_new       = en_q & ~finish_mask_q & finish_process;
    all_fin       = ((finish_mask_q | (finish_process & en_q)) == en_q);
    tmo_hit       = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      en_q          <= '0;
      start_q       <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      finish_mask_q <= '0;
      cycle_count_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) latency_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            en_q          <= core_en;
            cycle_count_q <= '0;
            finish_mask_q <= '0;
            timeout_q     <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) latency_q[i] <= '0;
            // An empty enable mask completes immediately without touching start.
            if (core_en == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              start_q <= '0;
            end else begin
              state_q <= ST_RUN;
              done_q  <= 1'b0;
              start_q <= core_en;
            end
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          finish_mask_q <= finish_mask_q | fin_new;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (fin_new[i]) latency_q[i] <= cycle_count_q;
          end
          // Completion takes priority over a timeout landing on the same edge.
          if (all_fin) begin
            state_q <= ST_DONE;
            start_q <= '0;
            done_q  <= 1'b1;
          end else if (tmo_hit) begin
            state_q   <= ST_DONE;
            start_q   <= '0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_lat
    assign latency_flat[g*CNT_W +: CNT_W] = latency_q[g];
  end

  assign busy        = (state_q == ST_RUN);
  assign start       = start_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign finish_mask = finish_mask_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_processor_run_monitor.sv
// Directed bench for processor_run_monitor: a 2-core instance with a 100-cycle
// budget plus a narrow-counter, no-timeout instance for saturation.
module tb_processor_run_monitor;

  logic        clk;
  logic        reset;
  logic        go;
  logic [1:0]  core_en;
  logic [1:0]  finish_process;
  logic [1:0]  start;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [1:0]  finish_mask;
  logic [15:0] cycle_count;
  logic [31:0] latency_flat;

  logic        go2;
  logic [0:0]  en2;
  logic [0:0]  fin2;
  logic [0:0]  start2;
  logic        busy2;
  logic        done2;
  logic        timeout2;
  logic [0:0]  mask2;
  logic [3:0]  count2;
  logic [3:0]  lat2;

  int n_checks = 0;
  int n_errors = 0;

  processor_run_monitor #(.NUM_CORES(2), .CNT_W(16), .TIMEOUT_CYCLES(100)) u_dut (
    .clk(clk), .reset(reset), .go(go), .core_en(core_en),
    .finish_process(finish_process), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .finish_mask(finish_mask), .cycle_count(cycle_count),
    .latency_flat(latency_flat)
  );

  processor_run_monitor #(.NUM_CORES(1), .CNT_W(4), .TIMEOUT_CYCLES(0)) u_sat (
    .clk(clk), .reset(reset), .go(go2), .core_en(en2),
    .finish_process(fin2), .start(start2), .busy(busy2), .done(done2),
    .timeout(timeout2), .finish_mask(mask2), .cycle_count(count2),
    .latency_flat(lat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go_pulse(input logic [1:0] en);
    go      = 1'b1;
    core_en = en;
    @(negedge clk);
    go      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; core_en = '0; finish_process = '0;
    go2 = 1'b0; en2 = '0; fin2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_start", start, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_mask", finish_mask, 2'b00);
    check("rst_count", cycle_count, 16'd0);
    check("rst_lat", latency_flat, 32'd0);

    // Core0 at cycle 5, core1 at cycle 12
    go_pulse(2'b11);
    check("t1_start", start, 2'b11);
    check("t1_busy", busy, 1'b1);
    check("t1_count0", cycle_count, 16'd0);
    for (int k = 0; k <= 12; k++) begin
      finish_process = {k >= 12, k >= 5};
      @(negedge clk);
      if (k == 5) begin
        check("t1_mask_mid", finish_mask, 2'b01);
        check("t1_done_mid", done, 1'b0);
      end
    end
    finish_process = '0;
    check("t1_done", done, 1'b1);
    check("t1_timeout", timeout, 1'b0);
    check("t1_busy_end", busy, 1'b0);
    check("t1_start_end", start, 2'b00);
    check("t1_mask", finish_mask, 2'b11);
    check("t1_lat0", latency_flat[15:0], 16'd5);
    check("t1_lat1", latency_flat[31:16], 16'd12);
    check("t1_count", cycle_count, 16'd13);
    @(negedge clk);
    check("t1_hold_done", done, 1'b1);
    check("t1_hold_count", cycle_count, 16'd13);

    // Timeout: only core0 finishes at cycle 7
    go_pulse(2'b11);
    check("t2_done_clr", done, 1'b0);
    check("t2_mask_clr", finish_mask, 2'b00);
    check("t2_lat_clr", latency_flat, 32'd0);
    for (int k = 0; k <= 99; k++) begin
      finish_process = {1'b0, k >= 7};
      @(negedge clk);
      if (k == 98) begin
        check("t2_busy_98", busy, 1'b1);
        check("t2_done_98", done, 1'b0);
      end
    end
    finish_process = '0;
    check("t2_done", done, 1'b1);
    check("t2_timeout", timeout, 1'b1);
    check("t2_mask", finish_mask, 2'b01);
    check("t2_lat0", latency_flat[15:0], 16'd7);
    check("t2_lat1", latency_flat[31:16], 16'd0);
    check("t2_count", cycle_count, 16'd100);
    check("t2_start", start, 2'b00);

    // Both finish on the timeout edge: completion wins
    go_pulse(2'b11);
    check("t3_timeout_clr", timeout, 1'b0);
    for (int k = 0; k <= 99; k++) begin
      finish_process = (k >= 99) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    finish_process = '0;
    check("t3_done", done, 1'b1);
    check("t3_timeout", timeout, 1'b0);
    check("t3_mask", finish_mask, 2'b11);
    check("t3_lat0", latency_flat[15:0], 16'd99);
    check("t3_lat1", latency_flat[31:16], 16'd99);

    // Finish on a disabled core is ignored
    go_pulse(2'b01);
    check("t4_start", start, 2'b01);
    for (int k = 0; k <= 4; k++) begin
      finish_process = {k == 3, k >= 4};
      @(negedge clk);
      if (k == 3) begin
        check("t4_mask_mid", finish_mask, 2'b00);
        check("t4_busy_mid", busy, 1'b1);
      end
    end
    finish_process = '0;
    check("t4_done", done, 1'b1);
    check("t4_mask", finish_mask, 2'b01);
    check("t4_lat0", latency_flat[15:0], 16'd4);
    check("t4_lat1", latency_flat[31:16], 16'd0);

    // Empty run
    go_pulse(2'b00);
    check("e_done", done, 1'b1);
    check("e_start", start, 2'b00);
    check("e_busy", busy, 1'b0);
    check("e_mask", finish_mask, 2'b00);
    check("e_count", cycle_count, 16'd0);
    @(negedge clk);
    check("e_start_hold", start, 2'b00);

    // Reset mid-run wins over finish and go
    go_pulse(2'b11);
    repeat (20) @(negedge clk);
    check("t5_count20", cycle_count, 16'd20);
    reset = 1'b1; finish_process = 2'b11; go = 1'b1; core_en = 2'b11;
    @(negedge clk);
    reset = 1'b0; finish_process = '0; go = 1'b0;
    check("t5_start", start, 2'b00);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_mask", finish_mask, 2'b00);
    check("t5_count", cycle_count, 16'd0);
    check("t5_lat", latency_flat, 32'd0);

    // go held through RUN does not restart the counter
    go = 1'b1; core_en = 2'b11;
    @(negedge clk);
    check("t6_count0", cycle_count, 16'd0);
    check("t6_start", start, 2'b11);
    for (int k = 0; k <= 3; k++) begin
      go = (k < 3);
      finish_process = (k >= 3) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (k == 2) check("t6_count3", cycle_count, 16'd3);
    end
    finish_process = '0;
    check("t6_done", done, 1'b1);
    check("t6_lat0", latency_flat[15:0], 16'd3);
    check("t6_lat1", latency_flat[31:16], 16'd3);
    check("t6_count", cycle_count, 16'd4);
    go_pulse(2'b11);
    check("t6r_done", done, 1'b0);
    check("t6r_mask", finish_mask, 2'b00);
    check("t6r_start", start, 2'b11);
    check("t6r_lat", latency_flat, 32'd0);
    finish_process = 2'b11;
    @(negedge clk);
    finish_process = '0;
    check("t6r_done_end", done, 1'b1);
    check("t6r_mask_end", finish_mask, 2'b11);
    check("t6r_count", cycle_count, 16'd1);

    // Saturating counter with timeout disabled
    go2 = 1'b1; en2 = 1'b1;
    @(negedge clk);
    go2 = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_count", count2, 4'd15);
    check("sat_busy", busy2, 1'b1);
    check("sat_done", done2, 1'b0);
    fin2 = 1'b1;
    @(negedge clk);
    fin2 = 1'b0;
    check("sat_lat", lat2, 4'd15);
    check("sat_done_end", done2, 1'b1);
    check("sat_timeout", timeout2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/processor_run_monitor.md
Name: processor_run_monitor

Overview:
- Synthesizable run controller and cycle monitor for up to NUM_CORES processor instances, replacing bench-side polling of finish_process.
- On a go pulse it asserts a level start to each enabled core and counts cycles.
- Captures per-core finish latency, signals done when every enabled core has finished, and aborts with timeout after a configurable cycle budget.
- Sits between the top-level run trigger and the processor array, on the same clock as the processors.

Parameters:
NUM_CORES, 2, number of processor channels monitored (1..16)
CNT_W, 16, width of the cycle counter and of each latency field
TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout abort; 0 disables timeout

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
go  input  1  run request, sampled in IDLE and DONE only
core_en  input  NUM_CORES  per-core enable mask, sampled on the accepted go
finish_process  input  NUM_CORES  per-core finish level from the processors
start  output  NUM_CORES  per-core start level to the processors
busy  output  1  high while in RUN
done  output  1  run ended (all enabled finished or timeout), held until next go
timeout  output  1  run ended by timeout, held until next go
finish_mask  output  NUM_CORES  sticky per-core finished flags for the current run
cycle_count  output  CNT_W  RUN cycles elapsed, saturating
latency_flat  output  NUM_CORES*CNT_W  core i latency in bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous active-high. Reset wins over every other input in the same cycle, including mid-run.
- Reset values: state IDLE; start, finish_mask, cycle_count, latency_flat all zero; busy=done=timeout=0.
- FSM states: IDLE, RUN, DONE (2-bit encoding).
- busy is combinational from state (state==RUN). All other outputs are registered.
- IDLE or DONE with go=1, at that edge:
  - en_r<=core_en, cycle_count<=0, finish_mask<=0, latency_flat<=0, done<=0, timeout<=0.
  - If core_en==0: state stays or moves to DONE, done<=1, start stays 0 (empty run).
  - Otherwise: state<=RUN, start<=core_en. start is visible the cycle after go.
- RUN, every edge:
  - cycle_count<=cycle_count+1, saturating at all-ones (no wrap).
  - For each i with en_r[i]=1, finish_mask[i]=0 and finish_process[i]=1: finish_mask[i]<=1, latency[i]<=cycle_count (pre-increment value). A finish seen in the first RUN cycle gives latency 0.
  - Finish on non-enabled cores is ignored. A finish deasserting later does not clear finish_mask.
  - Completion: (finish_mask | (finish_process & en_r)) == en_r at the edge. Then state<=DONE, start<=0, done<=1, timeout stays 0.
  - Timeout: TIMEOUT_CYCLES!=0, cycle_count==TIMEOUT_CYCLES-1 and no completion. Then state<=DONE, start<=0, done<=1, timeout<=1. finish_mask and latencies keep their partial values; unfinished latencies stay 0.
  - Completion and timeout on the same edge: completion wins, timeout=0.
  - go during RUN is ignored.
- DONE: outputs hold. go restarts exactly as from IDLE.
- Boundaries:
  - cycle_count saturates at 2^CNT_W-1 when timeout is disabled.
  - TIMEOUT_CYCLES must be <= 2^CNT_W-1; an elaboration check enforces this.

Test Plan:
- Reset then go with core_en=2'b11. Core0 finish at RUN cycle 5, core1 at 12 -> latencies 5 and 12, finish_mask=11, done=1 the cycle after cycle 12, timeout=0, start=00.
- TIMEOUT_CYCLES=100, core_en=11, only core0 finishes at cycle 7 -> done=1, timeout=1 after 100 RUN cycles, finish_mask=01, latency0=7, latency1=0.
- Both cores finish on the same cycle 99 with TIMEOUT_CYCLES=100 -> done=1, timeout=0, both latencies 99.
- core_en=01, core1 pulses finish at cycle 3, core0 finishes at 4 -> finish_mask=01, done after cycle 4. core_en=00 -> done=1 the cycle after go, start never asserted.
- Assert reset at RUN cycle 20 -> next cycle all outputs zero, state IDLE. A following go starts a fresh run with cycle_count=0.
- go held high through RUN -> no restart. After DONE, a go pulse clears done/timeout/finish_mask and reasserts start.
